// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time word reads to
// instruction memory over a req/valid handshake, and drives the IF/ID
// pipeline register consumed by id_stage. Honours stall from the hazard
// unit and redirects from EX, discarding any fetch that is in flight when a
// redirect lands.
module if_stage #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   ADDR_SIZE = 10,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 imem_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] pc_plus4,
    output logic                 instr_valid
);

    // FETCH: a request is on the bus (or about to be).
    // HOLD : a response arrived under stall and is parked in the hold regs.
    // DRAIN: a redirect orphaned an outstanding request; swallow its response.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WORD_SIZE-1:0] PC_STEP    = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

    state_t               r_state;
    state_t               w_state_next;

    logic [WORD_SIZE-1:0] r_pc;
    logic [WORD_SIZE-1:0] w_pc_next;
    logic [WORD_SIZE-1:0] w_pc_inc;
    logic [WORD_SIZE-1:0] w_redirect_target;

    logic [WORD_SIZE-1:0] r_hold_instr;
    logic [WORD_SIZE-1:0] r_hold_pc;
    logic                 w_hold_load;

    logic [WORD_SIZE-1:0] r_instr;
    logic [WORD_SIZE-1:0] r_pc_out;
    logic [WORD_SIZE-1:0] r_pc_plus4;
    logic                 r_instr_valid;
    logic [WORD_SIZE-1:0] w_instr_next;
    logic [WORD_SIZE-1:0] w_pc_out_next;
    logic [WORD_SIZE-1:0] w_pc_plus4_next;
    logic                 w_instr_valid_next;

    // PC arithmetic wraps naturally at 2^WORD_SIZE.
    assign w_pc_inc          = r_pc + PC_STEP;
    assign w_redirect_target = redirect_pc & ALIGN_MASK;

    // Upper PC bits alias onto the same imem word.
    assign imem_addr = r_pc[ADDR_SIZE+1:2];

    // Next-state, next-PC, IF/ID update and request generation.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_hold_load        = 1'b0;
        w_instr_next       = r_instr;
        w_pc_out_next      = r_pc_out;
        w_pc_plus4_next    = r_pc_plus4;
        w_instr_valid_next = r_instr_valid;
        imem_req           = 1'b0;

        case (r_state)
            FETCH: begin
                // Gated by rst so memory sees no request while in reset.
                imem_req = rst;
                if (redirect) begin
                    w_instr_next       = '0;
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = w_redirect_target;
                    // A same-cycle response is simply dropped; otherwise the
                    // outstanding one must be drained before refetching.
                    w_state_next       = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid) begin
                    w_pc_next = w_pc_inc;
                    if (!stall) begin
                        w_instr_next       = imem_rdata;
                        w_pc_out_next      = r_pc;
                        w_pc_plus4_next    = w_pc_inc;
                        w_instr_valid_next = 1'b1;
                    end else begin
                        w_hold_load  = 1'b1;
                        w_state_next = HOLD;
                    end
                end else if (!stall) begin
                    w_instr_next       = '0;
                    w_instr_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (redirect) begin
                    w_instr_next       = '0;
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = w_redirect_target;
                    w_state_next       = FETCH;
                end else if (!stall) begin
                    w_instr_next       = r_hold_instr;
                    w_pc_out_next      = r_hold_pc;
                    w_pc_plus4_next    = r_hold_pc + PC_STEP;
                    w_instr_valid_next = 1'b1;
                    w_state_next       = FETCH;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    w_instr_next       = '0;
                    w_instr_valid_next = 1'b0;
                    w_pc_next          = w_redirect_target;
                end
                if (imem_valid) begin
                    w_state_next = FETCH;
                end
            end

            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_pc_out      <= '0;
            r_pc_plus4    <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_instr       <= w_instr_next;
            r_pc_out      <= w_pc_out_next;
            r_pc_plus4    <= w_pc_plus4_next;
            r_instr_valid <= w_instr_valid_next;
        end
    end

    // Parked response captured under stall.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are only read in HOLD, after being written.
        if (w_hold_load) begin
            r_hold_instr <= imem_rdata;
            r_hold_pc    <= r_pc;
        end
    end

    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_plus4;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a variable-latency instruction memory,
// a behavioural fetch model compared every cycle, directed scenarios with
// literal expectations, then a randomized soak.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_stage #(
        .WORD_SIZE(32),
        .ADDR_SIZE(10),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .instr      (instr),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .instr_valid(instr_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory environment: one response per accepted request,
    // arriving lat cycles after acceptance (lat=0 means same cycle).
    logic [31:0] mem [0:1023];
    int          lat = 0;
    bit          mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [9:0]  mem_addr_q = '0;

    // Reference model: the fetch unit's observable state.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } park_t;

    logic [31:0] m_pc = RESET_PC;
    park_t       m_park[$];       // response parked under stall (0 or 1 entry)
    bit          m_orphan = 1'b0; // a response is owed and must be discarded
    logic [31:0] e_instr = '0;
    logic [31:0] e_pc    = '0;
    logic [31:0] e_pc4   = '0;
    logic        e_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mem_respond();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        if (!rst) begin
            mem_pending = 1'b0;
        end else begin
            if (!mem_pending && imem_req) begin
                mem_pending = 1'b1;
                mem_cnt     = 0;
                mem_addr_q  = imem_addr;
            end
            if (mem_pending) begin
                if (mem_cnt >= lat) begin
                    imem_valid  = 1'b1;
                    imem_rdata  = mem[mem_addr_q];
                    mem_pending = 1'b0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    endtask

    task automatic model_tick(input logic a_rst, input logic a_stall, input logic a_redir,
                              input logic [31:0] a_rpc, input logic a_valid,
                              input logic [31:0] a_rdata, input logic a_req);
        if (!a_rst) begin
            m_pc     = RESET_PC;
            m_park.delete();
            m_orphan = 1'b0;
            e_instr  = '0;
            e_pc     = '0;
            e_pc4    = '0;
            e_valid  = 1'b0;
        end else if (a_redir) begin
            // Anything in flight that did not answer this cycle is now orphaned.
            m_orphan = (a_req || m_orphan) && !a_valid;
            m_park.delete();
            m_pc     = a_rpc & ~32'd3;
            e_instr  = '0;
            e_valid  = 1'b0;
        end else if (m_orphan) begin
            if (a_valid) m_orphan = 1'b0;
        end else if (m_park.size() != 0) begin
            if (!a_stall) begin
                e_instr = m_park[0].instr;
                e_pc    = m_park[0].pc;
                e_pc4   = m_park[0].pc + 32'd4;
                e_valid = 1'b1;
                m_park.pop_front();
            end
        end else if (a_valid) begin
            if (a_stall) begin
                m_park.push_back(park_t'{instr: a_rdata, pc: m_pc});
            end else begin
                e_instr = a_rdata;
                e_pc    = m_pc;
                e_pc4   = m_pc + 32'd4;
                e_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!a_stall) begin
            e_instr = '0;
            e_valid = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, let memory answer, compare the request
    // side mid-cycle, advance the model at the edge and compare IF/ID after it.
    task automatic step(input logic a_rst, input logic a_stall, input logic a_redir,
                        input logic [31:0] a_rpc);
        logic exp_req;
        @(negedge clk);
        rst         = a_rst;
        stall       = a_stall;
        redirect    = a_redir;
        redirect_pc = a_rpc;
        #1;
        mem_respond();
        #1;
        exp_req = rst && (m_park.size() == 0) && !m_orphan;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
        @(posedge clk);
        model_tick(a_rst, a_stall, a_redir, a_rpc, imem_valid, imem_rdata, exp_req);
        #1;
        check("instr", instr, e_instr);
        check("pc_out", pc_out, e_pc);
        check("pc_plus4", pc_plus4, e_pc4);
        check("instr_valid", 32'(instr_valid), 32'(e_valid));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int pulses;
        int n_valid;
        logic          r_rst, r_stall, r_redir;
        logic [31:0]   r_rpc;

        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_valid = 1'b0; imem_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h00c00713;
        mem[1] = 32'h00ee8c33;
        mem[2] = 32'h200c2803;
        mem[4] = 32'h12fc5863;

        // 1: reset, then zero-latency streaming, one instruction per cycle.
        lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t1_reset_instr", instr, 32'h0);
        check("t1_reset_valid", 32'(instr_valid), 32'h0);
        check("t1_reset_pc4", pc_plus4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t1_instr0", instr, 32'h00c00713);
        check("t1_pc0", pc_out, 32'h0);
        check("t1_pc4_0", pc_plus4, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t1_instr1", instr, 32'h00ee8c33);
        check("t1_pc1", pc_out, 32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t1_instr2", instr, 32'h200c2803);
        check("t1_pc4_2", pc_plus4, 32'hC);
        check("t1_valid2", 32'(instr_valid), 32'h1);

        // 2: latency 2, request held three cycles, one valid pulse per fetch.
        lat = 2;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (i == 1) begin
                check("t2_req_held", 32'(imem_req), 32'h1);
                check("t2_addr_held", 32'(imem_addr), 32'h0);
                check("t2_bubble", instr, 32'h0);
            end
            if (instr_valid) pulses++;
        end
        check("t2_pulses", 32'(pulses), 32'd3);

        // 3: stall while the response for 0x10 returns, then release.
        lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        run(4);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_hold_pc", pc_out, 32'hC);
        check("t3_hold_req", 32'(imem_req), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        check("t3_still_held", pc_out, 32'hC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_rel_instr", instr, 32'h12fc5863);
        check("t3_rel_pc", pc_out, 32'h10);
        check("t3_rel_pc4", pc_plus4, 32'h14);
        check("t3_next_addr", 32'(imem_addr), 32'h5);
        check("t3_next_req", 32'(imem_req), 32'h1);

        // 4: redirect to 0x130 with a latency-3 request outstanding.
        lat = 3;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        run(2);
        step(1'b1, 1'b0, 1'b1, 32'h130);
        check("t4_drain_req", 32'(imem_req), 32'h0);
        check("t4_flush_valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_refetch_req", 32'(imem_req), 32'h1);
        check("t4_refetch_addr", 32'(imem_addr), 32'h4C);
        check("t4_no_spurious", 32'(instr_valid), 32'h0);
        run(4);
        check("t4_target_pc", pc_out, 32'h130);
        check("t4_target_valid", 32'(instr_valid), 32'h1);

        // 5: redirect and stall together in HOLD.
        lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h1F03);
        check("t5_addr", 32'(imem_addr), 32'h3C0);
        check("t5_req", 32'(imem_req), 32'h1);
        check("t5_valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t5_pc", pc_out, 32'h1F00);

        // 6: reset in the middle of a latency-2 fetch at 0x40.
        step(1'b0, 1'b0, 1'b0, 32'h0);
        run(16);
        lat = 2;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_pre_addr", 32'(imem_addr), 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("t6_rst_req", 32'(imem_req), 32'h0);
        check("t6_rst_pc", pc_out, 32'h0);
        check("t6_rst_valid", 32'(instr_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_first_req", 32'(imem_req), 32'h1);
        check("t6_first_addr", 32'(imem_addr), 32'h0);
        run(3);

        // PC wrap: 0xFFFFFFFC + 4 = 0.
        lat = 0;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc4", pc_plus4, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_next_pc", pc_out, 32'h0);

        // Randomized soak against the model.
        n_valid = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) lat = $urandom_range(0, 3);
            r_rst   = ($urandom_range(0, 199) != 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
            step(r_rst, r_stall, r_redir, r_rpc);
            if (instr_valid) n_valid++;
        end
        check("random_progress", 32'(n_valid > 200), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage. It is the producer end of the IF/ID interface that id_stage consumes.
- It owns the PC and issues word reads to instruction memory over a req/valid handshake.
- It holds the IF/ID pipeline register (instr, pc_out, pc_plus4, instr_valid).
- It honours stall from the hazard unit and redirects from EX (branch taken / jump), discarding in-flight fetches on redirect.

Parameters:
- WORD_SIZE, 32, instruction and PC width.
- ADDR_SIZE, 10, imem word-address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low.
- stall  in  1  hold the IF/ID register and suppress new fetch issue.
- redirect  in  1  branch-taken or jump from EX; flushes IF.
- redirect_pc  in  WORD_SIZE  new PC; bits [1:0] are forced to 0.
- imem_req  out  1  fetch request; held high with a stable imem_addr until imem_valid.
- imem_addr  out  ADDR_SIZE  word address, pc[ADDR_SIZE+1:2].
- imem_rdata  in  WORD_SIZE  fetched instruction; sampled only when imem_valid=1.
- imem_valid  in  1  one-cycle response; one per accepted request; latency L>=0 cycles (may arrive in the same cycle as req).
- instr  out  WORD_SIZE  IF/ID instruction; 32'h0 (the ID NOP) when invalid.
- pc_out  out  WORD_SIZE  PC of instr.
- pc_plus4  out  WORD_SIZE  pc_out+4, used as the link value for jal/jalr.
- instr_valid  out  1  instr holds a real fetched instruction.

Behaviour:
- **Reset** (rst==0 at posedge), from any state:
  - pc<=RESET_PC, state<=FETCH.
  - instr=0, pc_out=0, pc_plus4=0, instr_valid=0.
  - imem_req is gated to 0 combinationally while rst==0.
  - imem is reset by the same rst; responses still pending at reset are abandoned.
- **State FETCH:** imem_req=1, imem_addr=pc[ADDR_SIZE+1:2]. Per-cycle priority:
  - redirect=1:
    - Flush IF/ID (instr_valid<=0, instr<=0) and set pc<=redirect_pc&~3.
    - If imem_valid=1 this cycle, the response is dropped and state stays FETCH.
    - Otherwise state<=DRAIN.
  - imem_valid=1 and stall=0:
    - IF/ID <= {imem_rdata, pc, pc+4, valid=1}; pc<=pc+4.
    - Stay in FETCH; the next request issues the following cycle.
    - With L=0 this gives 1 instr/cycle.
  - imem_valid=1 and stall=1:
    - hold_instr<=imem_rdata, hold_pc<=pc; pc<=pc+4.
    - IF/ID unchanged; state<=HOLD.
  - imem_valid=0 and stall=0: IF/ID becomes a bubble (instr_valid<=0, instr<=0).
  - imem_valid=0 and stall=1: IF/ID holds.
- **State HOLD:** imem_req=0.
  - redirect: discard hold, flush IF/ID, pc<=redirect_pc, state<=FETCH.
  - stall=0: IF/ID <= {hold_instr, hold_pc, hold_pc+4, 1}; state<=FETCH.
  - stall=1: everything holds.
- **State DRAIN:** imem_req=0; waiting for an orphaned response.
  - imem_valid=1: the response is discarded; state<=FETCH.
  - A redirect in DRAIN overwrites pc with the latest redirect_pc and keeps IF/ID flushed.
  - If redirect and imem_valid occur in the same cycle: pc<=redirect_pc and state<=FETCH.
- **General rules:**
  - redirect always beats stall.
  - A flushed or discarded instruction never appears with instr_valid=1.
  - The PC wraps modulo 2^WORD_SIZE (32'hFFFF_FFFC+4=0); no exception is raised.
  - imem_addr uses only pc[ADDR_SIZE+1:2]; upper bits alias.
  - At most one outstanding request.
  - imem_addr is stable while imem_req=1 and no response has arrived.
  - pc_plus4 is registered, not recomputed combinationally.

Test Plan:
1. Reset then run, memory L=0, words at 0,4,8 = 00c00713, 00ee8c33, 200c2803 → one instr/cycle with pc_out 0,4,8; instr_valid=1; pc_plus4 = 4,8,12.
2. Memory L=2 → imem_req stays high with imem_addr stable for 3 cycles per fetch; instr_valid pulses once per fetch; bubbles show instr=0.
3. stall=1 for 3 cycles while a response returns for pc=0x10 (instr 12fc5863) → IF/ID holds its old value, FSM enters HOLD with imem_req=0; on stall release instr=12fc5863, pc_out=0x10, then fetch resumes at 0x14.
4. redirect=1, redirect_pc=0x130 with L=3 and a request outstanding → IF/ID flushed; DRAIN drops the late response; the next imem_addr is 0x4C; no spurious instr_valid.
5. redirect and stall both asserted in HOLD, redirect_pc=0x1F03 → hold discarded; pc becomes 0x1F00; imem_addr=0x3C0 next cycle.
6. rst=0 asserted mid-L=2 fetch with pc=0x40 → next cycle all outputs 0; imem_req=0 while rst==0; the first request after rst=1 uses addr 0.
